// File: rtl/uart_cfg.sv
// Full-duplex UART, configurable width/stop/oversample; rx_valid ~1 clk after mid-stop sample; no backpressure (tx_send ignored while tx_busy).
// Optional parity bit in both directions when UART_CFG_PARITY_EN is defined (PARITY_ODD selects odd).
module uart_cfg #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_send,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  input  logic                 rx,
  output logic                 tx
);

  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] DIV_M1     = DW'(DIV - 1);
  localparam logic [OW-1:0] OS_M1      = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_HALF_M1 = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    DB_M1      = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_M1      = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
      DIV < 1) begin : g_bad_cfg
    $error("uart_cfg: illegal parameter combination");
  end

`ifdef UART_CFG_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
`endif

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_CFG_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_CFG_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP, RX_BREAK
  } rx_state_e;

  // ---------------- transmitter ----------------
  tx_state_e             tx_state_q, tx_state_d;
  logic [DW-1:0]         tx_div_q, tx_div_d;
  logic [OW-1:0]         tx_os_q, tx_os_d;
  logic [3:0]            tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
  logic                  tx_q, tx_d;
  logic                  tx_busy_q, tx_busy_d;
  logic                  tx_tick, tx_bit_end;
`ifdef UART_CFG_PARITY_EN
  logic                  tx_par_q, tx_par_d;
`endif

  // Divider restarts on an accepted send so every frame is exactly N bit times.
  assign tx_tick    = (tx_div_q == DIV_M1);
  assign tx_bit_end = tx_tick && (tx_os_q == OS_M1);

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_div_q   <= '0;
      tx_os_q    <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
`ifdef UART_CFG_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_os_q    <= tx_os_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
`ifdef UART_CFG_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_div_q;
    tx_os_d    = tx_os_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
`ifdef UART_CFG_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (tx_state_q == TX_IDLE) begin
      if (tx_send) begin
        tx_state_d = TX_START;
        tx_div_d   = '0;
        tx_os_d    = '0;
        tx_bit_d   = '0;
        tx_shift_d = tx_data;
`ifdef UART_CFG_PARITY_EN
        tx_par_d   = (^tx_data) ^ PAR_ODD;
`endif
      end
    end else begin
      tx_div_d = tx_tick ? '0 : tx_div_q + 1'b1;
      if (tx_tick) tx_os_d = (tx_os_q == OS_M1) ? '0 : tx_os_q + 1'b1;
      if (tx_bit_end) begin
        case (tx_state_q)
          TX_START: begin
            tx_state_d = TX_DATA;
            tx_bit_d   = '0;
          end
          TX_DATA: begin
            tx_shift_d = tx_shift_q >> 1;
            if (tx_bit_q == DB_M1) begin
              tx_bit_d   = '0;
`ifdef UART_CFG_PARITY_EN
              tx_state_d = TX_PARITY;
`else
              tx_state_d = TX_STOP;
`endif
            end else begin
              tx_bit_d = tx_bit_q + 1'b1;
            end
          end
`ifdef UART_CFG_PARITY_EN
          TX_PARITY: begin
            tx_state_d = TX_STOP;
            tx_bit_d   = '0;
          end
`endif
          TX_STOP: begin
            if (tx_bit_q == SB_M1) tx_state_d = TX_IDLE;
            else                   tx_bit_d   = tx_bit_q + 1'b1;
          end
          default: tx_state_d = TX_IDLE;
        endcase
      end
    end
  end

  // Line level is decoded from the next state so tx leaves a flop, glitch-free.
  always_comb begin
    tx_busy_d = (tx_state_d != TX_IDLE);
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shift_d[0];
`ifdef UART_CFG_PARITY_EN
      TX_PARITY: tx_d = tx_par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;

  // ---------------- receiver ----------------
  rx_state_e             rx_state_q, rx_state_d;
  logic                  rx_meta_q, rx_sync_q, rx_last_q;
  logic [DW-1:0]         rx_div_q, rx_div_d;
  logic [OW-1:0]         rx_os_q, rx_os_d;
  logic [3:0]            rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_frame_err_q, rx_frame_err_d;
  logic                  rx_tick, rx_sample;
`ifdef UART_CFG_PARITY_EN
  logic                  rx_par_q, rx_par_d;
  logic                  rx_parity_err_q, rx_parity_err_d;
`endif

  assign rx_tick   = (rx_div_q == DIV_M1);
  assign rx_sample = rx_tick && (rx_os_q == ((rx_state_q == RX_START) ? OS_HALF_M1 : OS_M1));

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q     <= RX_IDLE;
      rx_meta_q      <= 1'b1;
      rx_sync_q      <= 1'b1;
      rx_last_q      <= 1'b1;
      rx_div_q       <= '0;
      rx_os_q        <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
`ifdef UART_CFG_PARITY_EN
      rx_par_q        <= 1'b0;
      rx_parity_err_q <= 1'b0;
`endif
    end else begin
      rx_state_q     <= rx_state_d;
      rx_meta_q      <= rx;
      rx_sync_q      <= rx_meta_q;
      rx_last_q      <= rx_sync_q;
      rx_div_q       <= rx_div_d;
      rx_os_q        <= rx_os_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
`ifdef UART_CFG_PARITY_EN
      rx_par_q        <= rx_par_d;
      rx_parity_err_q <= rx_parity_err_d;
`endif
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
`ifdef UART_CFG_PARITY_EN
    rx_par_d   = rx_par_q;
`endif
    if (rx_state_q != RX_IDLE && rx_state_q != RX_BREAK) begin
      rx_div_d = rx_tick ? '0 : rx_div_q + 1'b1;
      if (rx_tick) rx_os_d = (rx_os_q == OS_M1) ? '0 : rx_os_q + 1'b1;
    end
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_last_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_div_d   = '0;
          rx_os_d    = '0;
        end
      end
      RX_START: begin
        // Mid-start sample realigns the bit counter so later samples land mid-bit.
        if (rx_sample) begin
          rx_os_d  = '0;
          rx_bit_d = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DB_M1) begin
`ifdef UART_CFG_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
`ifdef UART_CFG_PARITY_EN
      RX_PARITY: begin
        if (rx_sample) begin
          rx_par_d   = rx_sync_q;
          rx_state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (rx_sample)
          rx_state_d = (!rx_sync_q && rx_shift_q == '0) ? RX_BREAK : RX_IDLE;
      end
      RX_BREAK: begin
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_valid_d     = (rx_state_q == RX_STOP) && rx_sample;
    rx_frame_err_d = rx_valid_d && !rx_sync_q;
    rx_data_d      = rx_valid_d ? rx_shift_q : rx_data_q;
`ifdef UART_CFG_PARITY_EN
    rx_parity_err_d = rx_valid_d && (rx_par_q != ((^rx_shift_q) ^ PAR_ODD));
`endif
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
`ifdef UART_CFG_PARITY_EN
  assign rx_parity_err = rx_parity_err_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg at a scaled baud rate (DIV=4, 64 clocks per bit).
module tb_uart_cfg;
  localparam int BIT = 64;
`ifdef UART_CFG_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BIT;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx_send = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy, rx_valid, rx_frame_err, rx_parity_err, tx;
  logic [7:0] rx_data;
  logic       rx_line;

  int         n_checks = 0;
  int         n_fail = 0;
  int         rx_cnt = 0;
  int         busy_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_ferr = 1'b0;
  logic       last_perr = 1'b0;

  assign rx_line = loop ? tx : rx_drv;

  uart_cfg #(
    .CLOCK_FREQ(1_000_000), .BAUD_RATE(15_625), .DATA_BITS(8),
    .STOP_BITS(1), .OVERSAMPLE(16), .PARITY_ODD(0)
  ) dut (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_send(tx_send),
    .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .rx(rx_line), .tx(tx)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (tx_busy) busy_cnt++;
    if (!reset && rx_valid) begin
      last_data = rx_data;
      last_ferr = rx_frame_err;
      last_perr = rx_parity_err;
      rx_cnt++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clock); #1;
    tx_data = b;
    tx_send = 1'b1;
    @(posedge clock); #1;
    tx_send = 1'b0;
  endtask

  task automatic wait_rx(input int target, input string tag);
    int t = 0;
    while (rx_cnt < target && t < 2 * FRAME) begin
      @(negedge clock);
      t++;
    end
    check(tag, rx_cnt, target);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (tx_busy && t < 2 * FRAME) begin
      @(negedge clock);
      t++;
    end
    check(tag, int'(tx_busy), 0);
  endtask

  // Frame bits LSB first: start, data, [parity], stop. Without parity bit 10 is past the frame.
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic stop, input logic par);
`ifdef UART_CFG_PARITY_EN
    return {stop, par, b, 1'b0};
`else
    return {par, stop, b, 1'b0};
`endif
  endfunction

  task automatic drive_frame(input logic [10:0] fr);
    for (int i = 0; i < NBITS; i++) begin
      rx_drv = fr[i];
      repeat (BIT) @(posedge clock);
    end
    #1 rx_drv = 1'b1;
  endtask

  task automatic loop_byte(input logic [7:0] b);
    int r0 = rx_cnt;
    int b0 = busy_cnt;
    send(b);
    wait_rx(r0 + 1, "loop_rx_count");
    check("loop_rx_data", int'(last_data), int'(b));
    check("loop_frame_err", int'(last_ferr), 0);
    check("loop_parity_err", int'(last_perr), 0);
    wait_idle("loop_busy_drop");
    check("loop_busy_len", busy_cnt - b0, FRAME);
  endtask

  initial begin
    logic [7:0] bytes [5] = '{8'h55, 8'hA5, 8'h00, 8'hFF, 8'h3C};
    int r0, b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_frame_err", int'(rx_frame_err), 0);
    check("rst_parity_err", int'(rx_parity_err), 0);
    @(posedge clock); #1 reset = 1'b0;
    repeat (4) @(posedge clock);

    foreach (bytes[i]) loop_byte(bytes[i]);

    // A send request while busy is dropped and does not stretch the frame.
    r0 = rx_cnt;
    b0 = busy_cnt;
    send(8'h34);
    repeat (100) @(posedge clock);
    send(8'h12);
    wait_rx(r0 + 1, "busy_rx_count");
    check("busy_rx_data", int'(last_data), 8'h34);
    wait_idle("busy_drop");
    check("busy_len", busy_cnt - b0, FRAME);
    repeat (FRAME + BIT) @(negedge clock);
    check("busy_no_queue", rx_cnt, r0 + 1);
    check("busy_stays_low", int'(tx_busy), 0);

    // Open-loop framing error, then a clean frame.
    loop = 1'b0;
    r0 = rx_cnt;
    drive_frame(mk_frame(8'hC3, 1'b0, 1'b0));
    repeat (BIT) @(posedge clock);
    check("ferr_count", rx_cnt, r0 + 1);
    check("ferr_data", int'(last_data), 8'hC3);
    check("ferr_flag", int'(last_ferr), 1);
    drive_frame(mk_frame(8'h81, 1'b1, 1'b0));
    repeat (BIT) @(posedge clock);
    check("clean_count", rx_cnt, r0 + 2);
    check("clean_data", int'(last_data), 8'h81);
    check("clean_ferr", int'(last_ferr), 0);

    // Short low pulse is rejected as a glitch; rx_data is held.
    r0 = rx_cnt;
    @(posedge clock); #1 rx_drv = 1'b0;
    repeat (24) @(posedge clock);
    #1 rx_drv = 1'b1;
    repeat (2 * FRAME) @(negedge clock);
    check("glitch_no_valid", rx_cnt, r0);
    check("glitch_data_held", int'(rx_data), 8'h81);

    // Line held low: one break frame, nothing more until the line rises.
    @(posedge clock); #1 rx_drv = 1'b0;
    repeat (20 * BIT) @(posedge clock);
    check("break_count", rx_cnt, r0 + 1);
    check("break_data", int'(last_data), 0);
    check("break_ferr", int'(last_ferr), 1);
    #1 rx_drv = 1'b1;
    repeat (2 * BIT) @(posedge clock);
    check("break_after_rise", rx_cnt, r0 + 1);
    drive_frame(mk_frame(8'h66, 1'b1, 1'b0));
    repeat (BIT) @(posedge clock);
    check("break_rearm_count", rx_cnt, r0 + 2);
    check("break_rearm_data", int'(last_data), 8'h66);

`ifdef UART_CFG_PARITY_EN
    r0 = rx_cnt;
    drive_frame(mk_frame(8'h07, 1'b1, 1'b0));
    repeat (BIT) @(posedge clock);
    check("par_bad_count", rx_cnt, r0 + 1);
    check("par_bad_flag", int'(last_perr), 1);
    drive_frame(mk_frame(8'h07, 1'b1, 1'b1));
    repeat (BIT) @(posedge clock);
    check("par_good_count", rx_cnt, r0 + 2);
    check("par_good_flag", int'(last_perr), 0);
    check("par_good_data", int'(last_data), 8'h07);
`endif

    // One-cycle reset during the fourth data bit (a 0 on the line) of 0xF0.
    loop = 1'b1;
    r0 = rx_cnt;
    send(8'hF0);
    repeat (BIT + 3 * BIT + BIT / 2) @(posedge clock);
    check("mid_tx_low", int'(tx), 0);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    check("rst_mid_tx", int'(tx), 1);
    check("rst_mid_busy", int'(tx_busy), 0);
    reset = 1'b0;
    repeat (FRAME) @(negedge clock);
    check("rst_mid_no_valid", rx_cnt, r0);
    loop_byte(8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
